// File: rtl/integrador_sinaptico.sv
// Synaptic integrator: serially scans a delayed spike vector, sums the signed
// weights of the active inputs and presents a saturated current with a valid pulse.
module integrador_sinaptico #(
  parameter int W  = 32,
  parameter int WW = 16,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spk_valid,
  input  logic [W-1:0]         spk_vec,
  input  logic                 w_we,
  input  logic [$clog2(W)-1:0] w_addr,
  input  logic [WW-1:0]        w_data,
  output logic                 busy,
  output logic                 out_valid,
  output logic [OW-1:0]        I_syn,
  output logic                 overrun
);

  localparam int IW = $clog2(W);
  localparam int AW = WW + IW;

  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [IW:0]          W_LIM   = (IW + 1)'(W);
  localparam logic [IW-1:0]        IDX_LAST = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [W-1:0]           scan_vec;
  logic [W-1:0]           buf_vec;
  logic                   buf_full;
  logic [IW-1:0]          idx;
  logic signed [AW-1:0]   acc;
  logic signed [WW-1:0]   weights [W];

  logic signed [WW-1:0]   w_sel;
  logic signed [AW-1:0]   addend;
  logic signed [AW-1:0]   acc_sum;
  logic [OW-1:0]          sat_val;
  logic                   addr_ok;

  // Handshake: spk_valid has no ready. A vector is accepted on any edge where
  // spk_valid=1; busy is advisory and a vector offered while the one-deep
  // buffer is full is dropped and recorded in the sticky overrun flag.
  assign busy    = (state != IDLE) | buf_full;
  assign addr_ok = ({1'b0, w_addr} < W_LIM);

  always_comb begin
    w_sel   = weights[idx];
    addend  = '0;
    if (scan_vec[idx]) addend = AW'(w_sel);
    acc_sum = acc + addend;
  end

  always_comb begin
    sat_val = acc[OW-1:0];
    if (acc > SAT_MAX)      sat_val = SAT_MAX[OW-1:0];
    else if (acc < SAT_MIN) sat_val = SAT_MIN[OW-1:0];
  end

  // The scan reads weights[idx] combinationally, so a write on the same edge
  // is only seen by later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) weights[i] <= '0;
    end else if (w_we && addr_ok) begin
      weights[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_vec  <= '0;
      buf_vec   <= '0;
      buf_full  <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      I_syn     <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            // A vector parked during DONE starts here; a new one refills the buffer.
            scan_vec <= buf_vec;
            acc      <= '0;
            idx      <= '0;
            state    <= SCAN;
            if (spk_valid) buf_vec  <= spk_vec;
            else           buf_full <= 1'b0;
          end else if (spk_valid) begin
            scan_vec <= spk_vec;
            acc      <= '0;
            idx      <= '0;
            state    <= SCAN;
          end
        end

        SCAN: begin
          acc <= acc_sum;
          idx <= idx + IW'(1);
          if (idx == IDX_LAST) state <= DONE;
          if (spk_valid) begin
            if (!buf_full) begin
              buf_vec  <= spk_vec;
              buf_full <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end

        DONE: begin
          I_syn     <= sat_val;
          out_valid <= 1'b1;
          if (buf_full) begin
            scan_vec <= buf_vec;
            acc      <= '0;
            idx      <= '0;
            buf_full <= 1'b0;
            state    <= SCAN;
            if (spk_valid) overrun <= 1'b1;
          end else begin
            state <= IDLE;
            if (spk_valid) begin
              buf_vec  <= spk_vec;
              buf_full <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integrador_sinaptico.sv
// Bench for integrador_sinaptico: directed and random vectors checked against
// a plain weighted-sum model with saturation.
module tb_integrador_sinaptico;

  localparam int W   = 32;
  localparam int WW  = 16;
  localparam int OW  = 16;
  localparam int IW  = 5;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spk_valid = 1'b0;
  logic [W-1:0]  spk_vec = '0;
  logic          w_we = 1'b0;
  logic [IW-1:0] w_addr = '0;
  logic [WW-1:0] w_data = '0;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] I_syn;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int model_w [W];
  logic [OW-1:0] exp_q[$];
  int            exp_k[$];

  integrador_sinaptico #(.W(W), .WW(WW), .OW(OW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spk_valid(spk_valid),
    .spk_vec  (spk_vec),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .busy     (busy),
    .out_valid(out_valid),
    .I_syn    (I_syn),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Expected current: sum of weights of active inputs, clamped to OW bits.
  function automatic logic [OW-1:0] model_current(input logic [W-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) if (v[i]) s += model_w[i];
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return OW'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int val);
    w_we   = 1'b1;
    w_addr = IW'(a);
    w_data = WW'(val);
    tick();
    w_we = 1'b0;
    model_w[a] = val;
  endtask

  task automatic wait_out(input int k_start, output int k_end);
    bit got;
    int k;
    got = 0;
    k = k_start;
    while (!got && k < k_start + 200) begin
      tick();
      k++;
      if (out_valid) got = 1;
    end
    k_end = got ? k : -1;
  endtask

  task automatic run_vector(input logic [W-1:0] v, output int lat, output logic [OW-1:0] val);
    spk_valid = 1'b1;
    spk_vec   = v;
    tick();
    spk_valid = 1'b0;
    wait_out(0, lat);
    val = I_syn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, out_valid, overrun, I_syn} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b ov=%b overrun=%b I_syn=%0d, want all 0",
               busy, out_valid, overrun, $signed(I_syn));
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    int lat;
    logic [OW-1:0] val;
    write_w(5, 100);
    run_vector(W'(1) << 5, lat, val);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (val !== 16'd100) begin
      n_fail++;
      $display("FAIL single_value: got %0d want 100", $signed(val));
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_uniform();
    int lat;
    logic [OW-1:0] val;
    for (int i = 0; i < W; i++) write_w(i, 100);
    run_vector('1, lat, val);
    n_checks++;
    if (lat !== LAT || val !== 16'd3200) begin
      n_fail++;
      $display("FAIL uniform_ones: got lat=%0d I_syn=%0d want lat=%0d I_syn=3200", lat, $signed(val), LAT);
    end
    run_vector('0, lat, val);
    n_checks++;
    if (lat !== LAT || val !== 16'd0) begin
      n_fail++;
      $display("FAIL uniform_zero: got lat=%0d I_syn=%0d want lat=%0d I_syn=0", lat, $signed(val), LAT);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [OW-1:0] val;
    for (int i = 0; i < W; i++) write_w(i, 2000);
    run_vector('1, lat, val);
    n_checks++;
    if (val !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL sat_pos: got %0d want 32767", $signed(val));
    end
    for (int i = 0; i < W; i++) write_w(i, -2000);
    run_vector('1, lat, val);
    n_checks++;
    if (val !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_neg: got %0d want -32768", $signed(val));
    end
    for (int i = 0; i < W; i++) write_w(i, 1023);
    run_vector('1, lat, val);
    n_checks++;
    if (val !== 16'd32736) begin
      n_fail++;
      $display("FAIL sat_edge: got %0d want 32736", $signed(val));
    end
  endtask

  task automatic test_random();
    int lat;
    logic [OW-1:0] val;
    logic [OW-1:0] expv;
    logic [W-1:0]  v;
    logic [WW-1:0] r16;
    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        for (int i = 0; i < W; i++) begin
          r16 = WW'($urandom_range(0, 65535));
          if (it == 4) r16 = WW'($urandom_range(30000, 32767));
          write_w(i, int'($signed(r16)));
        end
      end
      v = W'($urandom);
      expv = model_current(v);
      run_vector(v, lat, val);
      n_checks++;
      if (lat !== LAT || val !== expv) begin
        n_fail++;
        $display("FAIL random_%0d: vec=%h got lat=%0d I_syn=%0d want lat=%0d I_syn=%0d",
                 it, v, lat, $signed(val), LAT, $signed(expv));
      end
    end
  endtask

  task automatic test_done_store();
    int k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [OW-1:0] ea;
    logic [OW-1:0] eb;
    a = W'($urandom);
    b = W'($urandom);
    ea = model_current(a);
    eb = model_current(b);
    spk_valid = 1'b1;
    spk_vec   = a;
    tick();
    spk_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    spk_valid = 1'b1;
    spk_vec   = b;
    tick();
    spk_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || I_syn !== ea) begin
      n_fail++;
      $display("FAIL done_store_a: got out_valid=%b I_syn=%0d want 1 %0d", out_valid, $signed(I_syn), $signed(ea));
    end
    wait_out(LAT, k);
    n_checks++;
    if (k !== 2 * LAT + 1 || I_syn !== eb) begin
      n_fail++;
      $display("FAIL done_store_b: got k=%0d I_syn=%0d want k=%0d I_syn=%0d", k, $signed(I_syn), 2 * LAT + 1, $signed(eb));
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL done_store_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v [3];
    int lat;
    logic [OW-1:0] val;
    logic [OW-1:0] e;
    int ek;
    for (int i = 0; i < 3; i++) v[i] = W'($urandom);
    exp_q.push_back(model_current(v[0]));
    exp_k.push_back(LAT);
    exp_q.push_back(model_current(v[1]));
    exp_k.push_back(2 * LAT);
    spk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      spk_vec = v[i];
      tick();
    end
    spk_valid = 1'b0;
    for (int k = 3; k < 3 * LAT + 10; k++) begin
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected out_valid at k=%0d I_syn=%0d, want none", k - 1, $signed(I_syn));
        end else begin
          e  = exp_q.pop_front();
          ek = exp_k.pop_front();
          if (I_syn !== e || k - 1 !== ek) begin
            n_fail++;
            $display("FAIL b2b_result: got k=%0d I_syn=%0d want k=%0d I_syn=%0d", k - 1, $signed(I_syn), ek, $signed(e));
          end
        end
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing: got %0d results outstanding want 0", exp_q.size());
      exp_q.delete();
      exp_k.delete();
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b want 1", overrun);
    end
    run_vector(W'($urandom), lat, val);
    n_checks++;
    if (overrun !== 1'b1 || lat !== LAT) begin
      n_fail++;
      $display("FAIL overrun_sticky: got overrun=%b lat=%0d want 1 %0d", overrun, lat, LAT);
    end
  endtask

  task automatic test_weight_rw();
    int k;
    int lat;
    logic [OW-1:0] val;
    logic [W-1:0] v;
    logic [OW-1:0] e_old;
    logic [OW-1:0] e_new;
    write_w(3, 50);
    write_w(7, -7);
    v = (W'(1) << 3) | (W'(1) << 7);
    e_old = model_current(v);
    spk_valid = 1'b1;
    spk_vec   = v;
    tick();
    spk_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    w_we   = 1'b1;
    w_addr = IW'(3);
    w_data = WW'(900);
    tick();
    w_we = 1'b0;
    model_w[3] = 900;
    e_new = model_current(v);
    wait_out(4, k);
    n_checks++;
    if (k !== LAT || I_syn !== e_old) begin
      n_fail++;
      $display("FAIL wr_same_index_old: got k=%0d I_syn=%0d want k=%0d I_syn=%0d", k, $signed(I_syn), LAT, $signed(e_old));
    end
    run_vector(v, lat, val);
    n_checks++;
    if (val !== e_new) begin
      n_fail++;
      $display("FAIL wr_same_index_new: got %0d want %0d", $signed(val), $signed(e_new));
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious;
    logic [OW-1:0] val;
    spk_valid = 1'b1;
    spk_vec   = '1;
    tick();
    spk_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, out_valid, overrun, I_syn} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b ov=%b overrun=%b I_syn=%0d, want all 0",
               busy, out_valid, overrun, $signed(I_syn));
    end
    for (int i = 0; i < W; i++) model_w[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid || busy) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL reset_mid_aborted: got %0d busy/out_valid cycles want 0", spurious);
    end
    write_w(1, 77);
    run_vector('1, lat, val);
    n_checks++;
    if (lat !== LAT || val !== model_current('1)) begin
      n_fail++;
      $display("FAIL reset_mid_weights: got lat=%0d I_syn=%0d want lat=%0d I_syn=77", lat, $signed(val), LAT);
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) model_w[i] = 0;
    test_reset();
    test_single();
    test_uniform();
    test_saturation();
    test_random();
    test_done_store();
    test_back_to_back();
    test_weight_rw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
